// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA1 memory-interface constants, FSM states and byte-order helper
package sha1_pkg;
  localparam logic [1:0] STATE_COMPUTE = 2'b10;
  localparam int SHA1_DIGEST_W = 160;
  localparam int SHA1_WORDS = 5;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;
  function automatic logic [31:0] change_endian(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/sha1_digest_shift.sv
// sha1_digest_shift: digest holding register, shifts left one word at a time so Hk sits in the top 32 bits
module sha1_digest_shift
  import sha1_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     shift,
  input  logic [SHA1_DIGEST_W-1:0] d,
  output logic [SHA1_DIGEST_W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[SHA1_DIGEST_W-33:0], 32'h0};
endmodule

// File: rtl/sha1_write_to_mem.sv
// sha1_write_to_mem: writes the finished SHA1 digest as five little-endian words to RAM port B
module sha1_write_to_mem
  import sha1_pkg::*;
#(
  parameter int NUM_WORDS = SHA1_WORDS,
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               state,
  input  logic                     finish,
  input  logic [SHA1_DIGEST_W-1:0] hash,
  input  logic [ADDR_W-1:0]        output_addr,
  output logic                     port_B_clk,
  output logic [ADDR_W-1:0]        port_B_addr,
  output logic                     port_B_we,
  output logic [31:0]              port_B_data_in,
  output logic                     busy,
  output logic                     done
);
  localparam logic [2:0] LAST = 3'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  wr_state_t fsm, fsm_nx;
  logic [2:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0] data_nx;
  logic we_nx, busy_nx, done_nx, load, shift;
  logic [SHA1_DIGEST_W-1:0] q;
  assign port_B_clk = clk;
  // H0 goes straight to the data register at capture, so only H1..H4 are held
  sha1_digest_shift u_shift (
    .clk(clk), .reset_n(reset_n), .load(load), .shift(shift),
    .d({hash[SHA1_DIGEST_W-33:0], 32'h0}), .q(q)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fsm <= IDLE;
      cnt <= '0;
      port_B_addr <= '0;
      port_B_data_in <= '0;
      port_B_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      fsm <= fsm_nx;
      cnt <= cnt_nx;
      port_B_addr <= addr_nx;
      port_B_data_in <= data_nx;
      port_B_we <= we_nx;
      busy <= busy_nx;
      done <= done_nx;
    end
  always_comb begin
    fsm_nx = fsm;
    cnt_nx = cnt;
    addr_nx = port_B_addr;
    data_nx = port_B_data_in;
    we_nx = port_B_we;
    busy_nx = busy;
    done_nx = done;
    load = 1'b0;
    shift = 1'b0;
    if (state != STATE_COMPUTE) begin
      fsm_nx = IDLE;
      cnt_nx = '0;
      we_nx = 1'b0;
      busy_nx = 1'b0;
      done_nx = 1'b0;
    end else begin
      case (fsm)
        IDLE: if (finish) begin
          fsm_nx = WRITE;
          load = 1'b1;
          cnt_nx = '0;
          addr_nx = output_addr & ~ADDR_W'(3);
          data_nx = change_endian(hash[SHA1_DIGEST_W-1 -: 32]);
          we_nx = 1'b1;
          busy_nx = 1'b1;
        end
        WRITE: if (cnt == LAST) begin
          fsm_nx = DONE;
          cnt_nx = '0;
          we_nx = 1'b0;
          busy_nx = 1'b0;
          done_nx = 1'b1;
        end else begin
          shift = 1'b1;
          cnt_nx = cnt + 3'd1;
          addr_nx = port_B_addr + STEP;
          data_nx = change_endian(q[SHA1_DIGEST_W-1 -: 32]);
        end
        DONE: ;
        default: fsm_nx = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_write_to_mem.sv
// tb_sha1_write_to_mem: randomized bench against a queue-based digest write-back model
module tb_sha1_write_to_mem;
  logic clk = 0, reset_n = 1, finish = 0, chk_en = 0;
  logic [1:0] state = 2'b00;
  logic [159:0] hash = '0;
  logic [15:0] output_addr = '0;
  logic port_B_clk, port_B_we, busy, done;
  logic [15:0] port_B_addr;
  logic [31:0] port_B_data_in;
  int errs = 0, checks = 0;
  typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
  wr_t pend[$];
  wr_t log_q[$];
  bit captured = 0;
  logic e_we = 0, e_busy = 0, e_done = 0;
  logic [15:0] e_addr = '0;
  logic [31:0] e_data = '0;
  logic [159:0] abc = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  logic [31:0] abc_d [5] = '{32'h363e99a9, 32'h6a810647, 32'h71253eba, 32'h6cc25078, 32'h9dd8d09c};
  logic [15:0] abc_a [5] = '{16'h0100, 16'h0104, 16'h0108, 16'h010c, 16'h0110};
  logic [15:0] wrap_a [5] = '{16'hfff8, 16'hfffc, 16'h0000, 16'h0004, 16'h0008};

  always #5 clk = ~clk;

  sha1_write_to_mem dut (
    .clk(clk), .reset_n(reset_n), .state(state), .finish(finish), .hash(hash),
    .output_addr(output_addr), .port_B_clk(port_B_clk), .port_B_addr(port_B_addr),
    .port_B_we(port_B_we), .port_B_data_in(port_B_data_in), .busy(busy), .done(done)
  );

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {<<8{w}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a capture queues all five writes; each compute-state edge retires one, then done.
  always @(posedge clk or negedge reset_n) begin
    wr_t w;
    if (!reset_n) begin
      pend.delete(); captured = 0;
      e_we = 0; e_busy = 0; e_done = 0; e_addr = '0; e_data = '0;
    end else if (state != 2'b10) begin
      pend.delete(); captured = 0;
      e_we = 0; e_busy = 0; e_done = 0;
    end else begin
      if (!captured && finish) begin
        captured = 1;
        for (int k = 0; k < 5; k++)
          pend.push_back({16'((output_addr & 16'hfffc) + 4 * k), swap(hash[159 - 32 * k -: 32])});
      end
      if (pend.size() > 0) begin
        w = pend.pop_front();
        e_we = 1; e_busy = 1; e_done = 0; e_addr = w.a; e_data = w.d;
      end else begin
        e_we = 0; e_busy = 0; e_done = captured;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("we", 32'(port_B_we), 32'(e_we));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("clk_out", 32'(port_B_clk), 32'(clk));
    if (e_we) begin
      chk("addr", 32'(port_B_addr), 32'(e_addr));
      chk("data", port_B_data_in, e_data);
    end
    if (port_B_we) log_q.push_back({port_B_addr, port_B_data_in});
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic enter(input logic [159:0] h, input logic [15:0] a);
    log_q.delete();
    hash = h; output_addr = a; state = 2'b10; finish = 1;
  endtask

  task automatic leave();
    state = 2'b00; finish = 0;
    step(2);
  endtask

  function automatic logic [159:0] rnd_hash();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1 reset_n = 0;
    chk_en = 1;
    step(3);
    chk("rst_we", 32'(port_B_we), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0); chk("rst_addr", 32'(port_B_addr), 0);
    chk("rst_data", port_B_data_in, 0);
    reset_n = 1;
    step(2);
    // "abc" digest, then finish held high long after done
    enter(abc, 16'h0100);
    step(6);
    chk("abc_done", 32'(done), 1);
    chk("abc_busy", 32'(busy), 0);
    step(20);
    chk("abc_done_held", 32'(done), 1);
    chk("abc_pulses", log_q.size(), 5);
    for (int k = 0; k < 5; k++) if (k < log_q.size()) begin
      chk("abc_addr", 32'(log_q[k].a), 32'(abc_a[k]));
      chk("abc_data", log_q[k].d, abc_d[k]);
    end
    leave();
    chk("abc_done_clr", 32'(done), 0);
    // abort at the third write, then full rewrite on re-entry
    enter(rnd_hash(), 16'($urandom));
    step(3);
    state = 2'b00;
    step(1);
    chk("abort_busy", 32'(busy), 0);
    finish = 0;
    step(3);
    chk("abort_pulses", log_q.size(), 3);
    chk("abort_done", 32'(done), 0);
    enter(rnd_hash(), 16'($urandom));
    step(8);
    chk("rewrite_pulses", log_q.size(), 5);
    leave();
    // address wrap and base alignment
    enter(rnd_hash(), 16'hfff8);
    step(8);
    for (int k = 0; k < 5; k++) if (k < log_q.size()) chk("wrap_addr", 32'(log_q[k].a), 32'(wrap_a[k]));
    leave();
    enter(rnd_hash(), 16'h0103);
    step(8);
    chk("align_n", log_q.size(), 5);
    if (log_q.size() > 0) chk("align_addr", 32'(log_q[0].a), 32'h0100);
    leave();
    // inputs churn during WRITE
    enter(rnd_hash(), 16'($urandom));
    for (int i = 0; i < 7; i++) begin
      step(1);
      hash = rnd_hash(); output_addr = 16'($urandom);
    end
    chk("churn_n", log_q.size(), 5);
    leave();
    // async reset between edges mid-WRITE
    enter(rnd_hash(), 16'h0200);
    step(2);
    #2 reset_n = 0;
    #1;
    chk("arst_we", 32'(port_B_we), 0); chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0); chk("arst_addr", 32'(port_B_addr), 0);
    finish = 0;
    step(1);
    reset_n = 1;
    step(6);
    chk("arst_pulses", log_q.size(), 2);
    leave();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      state = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b10;
      finish = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) hash = rnd_hash();
      output_addr = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin #2 reset_n = 0; #2 reset_n = 1; end
      step(1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
